// File: rtl/intr_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the interrupt controller.
package intr_ctrl_pkg;

  localparam logic [5:0] OP_INTR_ON  = 6'b101010;
  localparam logic [5:0] OP_INTR_OFF = 6'b101011;
  localparam logic [5:0] OP_RETURN   = 6'b101100;
  localparam logic [5:0] OP_SYSCALL  = 6'b101101;
  localparam logic [5:0] OP_HALT     = 6'b111111;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    COUNTING = 2'd1,
    FIRE     = 2'd2,
    HANDLER  = 2'd3
  } state_t;

  localparam int unsigned CAUSE_TIMER     = 0;
  localparam logic [31:0] PREEMP_INST_DEF = 32'hA4000012;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest-index request wins; cause is index+1.
module intr_prio_enc #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned CAUSE_W = $clog2(NUM_IRQ + 1)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [CAUSE_W-1:0] cause,
  output logic [NUM_IRQ-1:0] grant
);

  // Scan upward and latch onto the first set request.
  always_comb begin
    valid = 1'b0;
    cause = '0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && !valid) begin
        valid    = 1'b1;
        cause    = CAUSE_W'(i + 1);
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_multi.sv
// Preemption/interrupt controller sitting between instruction memory and decode.
// Timer plus NUM_IRQ maskable lines, fixed priority, non-nesting handler.
module intr_ctrl_multi
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned               ADDRESS_SIZE   = 32,
  parameter int unsigned               NUM_IRQ        = 4,
  parameter int unsigned               QUANTUM_W      = 8,
  parameter int unsigned               QUANTUM_RST    = 2**QUANTUM_W,
  parameter int unsigned               SYSCALL_CREDIT = 4,
  parameter logic [ADDRESS_SIZE-1:0]   PREEMP_INST    = PREEMP_INST_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDRESS_SIZE-1:0]          PCout,
  input  logic [1:0]                       PCDest,
  input  logic [ADDRESS_SIZE-1:0]          inst_mem,
  input  logic                             isHDOP,
  input  logic [1:0]                       isIO,
  input  logic [NUM_IRQ-1:0]               irq_req,
  input  logic                             irq_mask_we,
  input  logic [NUM_IRQ-1:0]               irq_mask_in,
  input  logic                             quantum_we,
  input  logic [QUANTUM_W:0]               quantum_in,
  output logic [ADDRESS_SIZE-1:0]          inst_out,
  output logic                             intr,
  output logic [$clog2(NUM_IRQ+1)-1:0]     intr_cause,
  output logic [ADDRESS_SIZE-1:0]          epc,
  output logic                             in_handler
);

  localparam int unsigned          CAUSE_W = $clog2(NUM_IRQ + 1);
  localparam logic [QUANTUM_W:0]   Q_RST   = (QUANTUM_W+1)'(QUANTUM_RST);
  localparam logic [QUANTUM_W-1:0] CREDIT  = QUANTUM_W'(SYSCALL_CREDIT);

  state_t               state, next_state;
  logic [QUANTUM_W-1:0] count;
  logic [QUANTUM_W:0]   quantum;
  logic [NUM_IRQ-1:0]   pending, irq_mask, grant;
  logic                 timer_pend;
  logic                 irq_valid;
  logic [CAUSE_W-1:0]   irq_cause;
  logic [5:0]           opcode;
  logic                 op_on, op_off, op_ret, op_sys, op_halt, op_stop;
  logic                 unstalled, expire, fire_req, fire_go;

  // Opcodes are ignored while the injected instruction is on the bus.
  assign opcode  = inst_mem[31:26];
  assign op_on   = !intr && (opcode == OP_INTR_ON);
  assign op_off  = !intr && (opcode == OP_INTR_OFF);
  assign op_ret  = !intr && (opcode == OP_RETURN);
  assign op_sys  = !intr && (opcode == OP_SYSCALL);
  assign op_halt = !intr && (opcode == OP_HALT);
  assign op_stop = op_off || op_halt;

  assign unstalled = (PCDest != 2'b01) && !isHDOP && (isIO == 2'b00);
  // >= rather than == so a quantum lowered under the running count expires promptly.
  assign expire    = ({1'b0, count} >= (quantum - (QUANTUM_W+1)'(1)));
  assign fire_req  = irq_valid || timer_pend;
  assign fire_go   = (state == COUNTING) && (next_state == FIRE);

  intr_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio (
    .req   (pending & irq_mask),
    .valid (irq_valid),
    .cause (irq_cause),
    .grant (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= DISABLED;
    else       state <= next_state;
  end

  // Next-state logic; stop opcodes outrank SYSCALL, which outranks delivery.
  always_comb begin
    next_state = state;
    case (state)
      DISABLED: if (op_on) next_state = COUNTING;
      COUNTING: begin
        if (op_stop)       next_state = DISABLED;
        else if (op_sys)   next_state = COUNTING;
        else if (fire_req) next_state = FIRE;
      end
      FIRE:     next_state = HANDLER;
      HANDLER: begin
        if (op_ret)       next_state = COUNTING;
        else if (op_stop) next_state = DISABLED;
      end
      default:  next_state = DISABLED;
    endcase
  end

  // Outputs decoded from state and the registered delivery pulse.
  always_comb begin
    in_handler = (state == HANDLER);
    inst_out   = intr ? PREEMP_INST : inst_mem;
  end

  // Counter, pending/mask/quantum registers and delivery capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      quantum    <= Q_RST;
      pending    <= '0;
      irq_mask   <= '1;
      timer_pend <= 1'b0;
      intr       <= 1'b0;
      intr_cause <= '0;
      epc        <= '0;
    end else begin
      intr <= fire_go;
      if (fire_go) begin
        epc        <= PCout;
        intr_cause <= irq_valid ? irq_cause : CAUSE_W'(CAUSE_TIMER);
      end

      // A still-asserted level re-pends the line after its delivery clears it.
      pending <= (pending & ~((fire_go && irq_valid) ? grant : '0)) | irq_req;

      if (irq_mask_we)                 irq_mask <= irq_mask_in;
      if (quantum_we && quantum_in != '0) quantum <= quantum_in;

      if ((state == COUNTING || state == HANDLER) && op_stop)
        timer_pend <= 1'b0;
      else if (fire_go && !irq_valid)
        timer_pend <= 1'b0;
      else if (state == COUNTING && !op_sys && !fire_req && unstalled && expire)
        timer_pend <= 1'b1;

      case (state)
        DISABLED: if (op_on) count <= '0;
        COUNTING: begin
          if (op_stop)       count <= '0;
          else if (op_sys)   count <= (count >= CREDIT) ? (count - CREDIT) : '0;
          else if (fire_req) count <= '0;
          else if (unstalled) count <= expire ? '0 : (count + QUANTUM_W'(1));
        end
        FIRE:     count <= '0;
        HANDLER:  if (op_ret || op_stop) count <= '0;
        default:  count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl_multi.sv
// Scoreboard bench for intr_ctrl_multi: expected deliveries are queued when
// the triggering stimulus is applied and retired when intr is observed.
module tb_intr_ctrl_multi;
  import intr_ctrl_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_1234;
  localparam logic [31:0] PINS = 32'hA4000012;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCout, inst_mem, inst_out, epc;
  logic [1:0]  PCDest, isIO;
  logic        isHDOP, irq_mask_we, quantum_we, intr, in_handler;
  logic [3:0]  irq_req, irq_mask_in;
  logic [8:0]  quantum_in;
  logic [2:0]  intr_cause;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] epc;
  } exp_t;
  exp_t sb[$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        prev_intr = 1'b0;

  always #5 clk = ~clk;

  intr_ctrl_multi #(
    .ADDRESS_SIZE   (32),
    .NUM_IRQ        (4),
    .QUANTUM_W      (8),
    .QUANTUM_RST    (256),
    .SYSCALL_CREDIT (4),
    .PREEMP_INST    (PINS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCout       (PCout),
    .PCDest      (PCDest),
    .inst_mem    (inst_mem),
    .isHDOP      (isHDOP),
    .isIO        (isIO),
    .irq_req     (irq_req),
    .irq_mask_we (irq_mask_we),
    .irq_mask_in (irq_mask_in),
    .quantum_we  (quantum_we),
    .quantum_in  (quantum_in),
    .inst_out    (inst_out),
    .intr        (intr),
    .intr_cause  (intr_cause),
    .epc         (epc),
    .in_handler  (in_handler)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, retire scoreboard entries on intr.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (intr) begin
      check("intr_not_back_to_back", 32'(prev_intr), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_intr", 32'(intr), 32'd0);
      end else begin
        e = sb.pop_front();
        check("intr_cause", 32'(intr_cause), 32'(e.cause));
        check("epc", epc, e.epc);
        check("inst_out_injected", inst_out, PINS);
      end
    end
    prev_intr = intr;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wait_intr(input string tag, input int unsigned limit, input int unsigned exp_lat);
    int unsigned lat = 0;
    for (int unsigned i = 1; i <= limit; i++) begin
      step();
      if (intr) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, exp_lat);
  endtask

  task automatic expect_intr(input logic [2:0] cause, input logic [31:0] pc);
    exp_t e;
    e.cause = cause;
    e.epc   = pc;
    sb.push_back(e);
  endtask

  task automatic op(input logic [5:0] code);
    inst_mem = {code, 26'h0};
    step();
    inst_mem = NOP;
  endtask

  task automatic set_quantum(input logic [8:0] q);
    quantum_we = 1'b1;
    quantum_in = q;
    step();
    quantum_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PCout = 32'h0000_1000; PCDest = 2'b00; inst_mem = NOP;
    isHDOP = 1'b0; isIO = 2'b00; irq_req = '0; irq_mask_we = 1'b0;
    irq_mask_in = '0; quantum_we = 1'b0; quantum_in = '0;

    // Reset state
    steps(2);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_in_handler", 32'(in_handler), 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_cause", 32'(intr_cause), 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
    check("rst_quantum", 32'(dut.quantum), 32'd256);
    check("rst_inst_out", inst_out, NOP);
    reset = 1'b0;
    step();

    // Timer expiry with quantum 4, no stalls
    set_quantum(9'd4);
    PCout = 32'h0000_2000;
    op(OP_INTR_ON);
    expect_intr(3'd0, 32'h0000_2000);
    wait_intr("timer_lat", 10, 5);
    inst_mem = 32'h0000_5678;
    step();
    check("handler_entered", 32'(in_handler), 32'd1);
    check("intr_dropped", 32'(intr), 32'd0);
    check("inst_out_passthru", inst_out, 32'h0000_5678);
    inst_mem = NOP;

    // IO stall freezes the count, counting resumes on release
    op(OP_RETURN);
    isIO = 2'b01;
    steps(10);
    check("stall_count_frozen", 32'(dut.count), 32'd0);
    isIO = 2'b00;
    PCout = 32'h0000_3000;
    expect_intr(3'd0, 32'h0000_3000);
    wait_intr("stall_release_lat", 10, 5);
    step();
    set_quantum(9'd200);
    op(OP_RETURN);

    // Simultaneous irq 2 and 0: lowest index first, then the other after RETURN
    PCout = 32'h0000_4000;
    irq_req = 4'b0101;
    expect_intr(3'd1, 32'h0000_4000);
    step();
    irq_req = '0;
    wait_intr("irq0_lat", 5, 1);
    step();
    PCout = 32'h0000_4400;
    op(OP_RETURN);
    expect_intr(3'd3, 32'h0000_4400);
    wait_intr("irq2_lat", 5, 1);
    step();
    op(OP_RETURN);

    // Masked irq stays pending, delivers once unmasked
    irq_mask_we = 1'b1; irq_mask_in = 4'b0000;
    step();
    irq_mask_we = 1'b0;
    irq_req = 4'b0010;
    step();
    irq_req = '0;
    steps(5);
    check("masked_pending", 32'(dut.pending), 32'h2);
    PCout = 32'h0000_5000;
    expect_intr(3'd2, 32'h0000_5000);
    irq_mask_we = 1'b1; irq_mask_in = 4'b1111;
    step();
    irq_mask_we = 1'b0;
    wait_intr("unmask_lat", 5, 1);
    step();
    op(OP_RETURN);

    // SYSCALL credit with saturation
    steps(2);
    check("count_before_sys_a", 32'(dut.count), 32'd2);
    op(OP_SYSCALL);
    check("syscall_saturate", 32'(dut.count), 32'd0);
    steps(9);
    check("count_before_sys_b", 32'(dut.count), 32'd9);
    op(OP_SYSCALL);
    check("syscall_refund", 32'(dut.count), 32'd5);

    // INTR_OFF in the cycle that would deliver a timer expiry
    op(OP_INTR_OFF);
    set_quantum(9'd4);
    op(OP_INTR_ON);
    steps(4);
    check("timer_pend_set", 32'(dut.timer_pend), 32'd1);
    op(OP_INTR_OFF);
    steps(6);
    check("off_state", 32'(dut.state), 32'(DISABLED));
    check("off_timer_pend", 32'(dut.timer_pend), 32'd0);
    // A zero quantum write is ignored, so the full quantum 4 latency reappears
    set_quantum(9'd0);
    PCout = 32'h0000_6000;
    op(OP_INTR_ON);
    expect_intr(3'd0, 32'h0000_6000);
    wait_intr("reenable_lat", 10, 5);
    step();
    check("handler_before_reset", 32'(in_handler), 32'd1);

    // Reset while in HANDLER
    reset = 1'b1;
    step();
    check("rst_mid_in_handler", 32'(in_handler), 32'd0);
    check("rst_mid_epc", epc, 32'd0);
    check("rst_mid_cause", 32'(intr_cause), 32'd0);
    check("rst_mid_intr", 32'(intr), 32'd0);
    reset = 1'b0;
    step();
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
